// File: rtl/apb_arb_pkg.sv
// Shared types and sizing for the round-robin APB requester arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int GNT_W    = 3;
   localparam int NREQ_DEF = 4;
   localparam int AW_DEF   = 4;
   localparam int DW_DEF   = 8;
   localparam int TMO_DEF  = 16;

   // Counter only has to reach TIMEOUT_CYC-1; keep at least one bit when disabled.
   function automatic int tmo_width(input int cyc);
      return (cyc < 2) ? 1 : $clog2(cyc);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module rr_priority_pick
   import apb_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]  req,
   input  logic [GNT_W-1:0] last_grant,
   output logic             vld,
   output logic [GNT_W-1:0] idx
);

   int pos;

   always_comb begin
      vld = 1'b0;
      idx = '0;
      pos = 0;
      for (int k = 1; k <= NREQ; k++) begin
         pos = (int'(last_grant) + k) % NREQ;
         if (!vld && req[pos]) begin
            vld = 1'b1;
            idx = GNT_W'(pos);
         end
      end
   end

endmodule

// File: rtl/apb_rr_req_arbiter.sv
// Shares one APB master among NREQ requesters, round-robin, one transfer in flight.
// A watchdog completes a transfer with err=1 if the slave never asserts pready.
module apb_rr_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NREQ        = NREQ_DEF,
   parameter int AW          = AW_DEF,
   parameter int DW          = DW_DEF,
   parameter int TIMEOUT_CYC = TMO_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      ack,
   output logic                 err,
   output logic [DW-1:0]        rdata,
   output logic                 busy,
   output logic [GNT_W-1:0]     gnt_id,
   output logic                 m_newd,
   output logic                 m_wr,
   output logic [AW-1:0]        m_ain,
   output logic [DW-1:0]        m_din,
   input  logic                 m_pready,
   input  logic [DW-1:0]        m_dout
);

   localparam int TW = tmo_width(TIMEOUT_CYC);
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [GNT_W-1:0] last_grant;
   logic [GNT_W-1:0] pick_idx;
   logic             pick_vld;
   logic [TW-1:0]    tmo_cnt;
   logic             tmo_hit;

   rr_priority_pick #(.NREQ(NREQ)) u_pick (
      .req        (req),
      .last_grant (last_grant),
      .vld        (pick_vld),
      .idx        (pick_idx)
   );

   assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = REQ;
         REQ:     if (m_pready || tmo_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_newd = (state == REQ);
      busy   = (state != IDLE);
   end

   // ack is registered on leaving REQ so it is high exactly for the RESP cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt_id     <= '0;
         last_grant <= GNT_W'(NREQ - 1);
         m_wr       <= 1'b0;
         m_ain      <= '0;
         m_din      <= '0;
         rdata      <= '0;
         err        <= 1'b0;
         ack        <= '0;
         tmo_cnt    <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (pick_vld) begin
                  gnt_id <= pick_idx;
                  m_wr   <= req_wr[int'(pick_idx)];
                  m_ain  <= req_addr[int'(pick_idx)*AW +: AW];
                  m_din  <= req_wdata[int'(pick_idx)*DW +: DW];
               end
            end
            REQ: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (m_pready) begin
                  rdata <= m_wr ? '0 : m_dout;
                  err   <= 1'b0;
                  ack   <= ONE << gnt_id;
               end else if (tmo_hit) begin
                  rdata <= '0;
                  err   <= 1'b1;
                  ack   <= ONE << gnt_id;
               end
            end
            RESP: begin
               last_grant <= gnt_id;
               tmo_cnt    <= '0;
            end
            default: tmo_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_rr_req_arbiter.sv
// Scoreboard bench: stimulus queues expected transfers/acks, monitors compare on DUT events.
module tb_apb_rr_req_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  req_wr = '0;
   logic [15:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  ack;
   logic        err;
   logic [7:0]  rdata;
   logic        busy;
   logic [2:0]  gnt_id;
   logic        m_newd;
   logic        m_wr;
   logic [3:0]  m_ain;
   logic [7:0]  m_din;
   logic        m_pready = 1'b0;
   logic [7:0]  m_dout = '0;

   int checks = 0;
   int errors = 0;
   int slave_wait = 0;
   logic [7:0] slave_data = '0;

   typedef struct {
      int         id;
      logic       err;
      logic [7:0] rdata;
   } ack_t;

   typedef struct {
      int         id;
      logic       wr;
      logic [3:0] addr;
      logic [7:0] din;
   } xfer_t;

   ack_t  exp_ack[$];
   xfer_t exp_xfer[$];

   apb_rr_req_arbiter #(.NREQ(4), .AW(4), .DW(8), .TIMEOUT_CYC(16)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .err       (err),
      .rdata     (rdata),
      .busy      (busy),
      .gnt_id    (gnt_id),
      .m_newd    (m_newd),
      .m_wr      (m_wr),
      .m_ain     (m_ain),
      .m_din     (m_din),
      .m_pready  (m_pready),
      .m_dout    (m_dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic setup(input int id, input logic wr, input logic [3:0] addr, input logic [7:0] din);
      req_wr[id]            = wr;
      req_addr[id*4 +: 4]   = addr;
      req_wdata[id*8 +: 8]  = din;
   endtask

   task automatic push(input int id, input logic wr, input logic [3:0] addr, input logic [7:0] din,
                       input logic e, input logic [7:0] rd);
      exp_xfer.push_back('{id, wr, addr, din});
      exp_ack.push_back('{id, e, rd});
   endtask

   task automatic wait_ack(input int id, input logic drop);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[id] && n < 200);
      if (!ack[id]) begin
         errors++;
         $display("FAIL wait_ack%0d actual=timeout required=ack", id);
      end
      if (drop) req[id] = 1'b0;
   endtask

   task automatic wait_newd();
      int n;
      n = 0;
      while (!m_newd && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("newd_seen", {31'd0, m_newd}, 32'd1);
   endtask

   // Slave: pready after slave_wait cycles of m_newd.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (m_newd) begin
            m_pready = (cnt == slave_wait);
            m_dout   = slave_data;
            cnt++;
         end else begin
            m_pready = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor: new transfer on m_newd rise, completion on ack.
   initial begin
      logic  prev_newd;
      ack_t  a;
      xfer_t x;
      prev_newd = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_newd = 1'b0;
         end else begin
            if (m_newd && !prev_newd) begin
               if (exp_xfer.size() == 0) begin
                  chk("xfer_unexpected", {29'd0, gnt_id}, 32'hFFFF);
               end else begin
                  x = exp_xfer.pop_front();
                  chk("xfer_gnt", {29'd0, gnt_id}, x.id);
                  chk("xfer_wr", {31'd0, m_wr}, {31'd0, x.wr});
                  chk("xfer_addr", {28'd0, m_ain}, {28'd0, x.addr});
                  chk("xfer_din", {24'd0, m_din}, {24'd0, x.din});
               end
            end
            if (ack != 4'd0) begin
               if (exp_ack.size() == 0) begin
                  chk("ack_unexpected", {28'd0, ack}, 32'd0);
               end else begin
                  a = exp_ack.pop_front();
                  chk("ack_onehot", {28'd0, ack}, 32'd1 << a.id);
                  chk("ack_err", {31'd0, err}, {31'd0, a.err});
                  chk("ack_rdata", {24'd0, rdata}, {24'd0, a.rdata});
                  chk("ack_newd_low", {31'd0, m_newd}, 32'd0);
               end
            end
            prev_newd = m_newd;
         end
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_newd", {31'd0, m_newd}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_ack", {28'd0, ack}, 32'd0);
      chk("idle_gnt", {29'd0, gnt_id}, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
      chk("idle_rdata", {24'd0, rdata}, 32'd0);

      // Single zero-wait write from requester 0.
      setup(0, 1'b1, 4'd3, 8'hA5);
      push(0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h00);
      req[0] = 1'b1;
      wait_ack(0, 1'b1);

      // Read with 3 wait cycles from requester 2.
      slave_wait = 3;
      slave_data = 8'h7C;
      setup(2, 1'b0, 4'd1, 8'h00);
      push(2, 1'b0, 4'd1, 8'h00, 1'b0, 8'h7C);
      req[2] = 1'b1;
      wait_ack(2, 1'b1);

      // Stalled slave: watchdog fires after 16 REQ cycles, then requester 0 is served.
      slave_wait = 1000;
      setup(3, 1'b0, 4'd5, 8'h00);
      push(3, 1'b0, 4'd5, 8'h00, 1'b1, 8'h00);
      req[3] = 1'b1;
      n = 0;
      for (int c = 0; c < 100 && !ack[3]; c++) begin
         @(negedge clk);
         if (m_newd) n++;
      end
      req[3] = 1'b0;
      chk("tmo_req_cycles", n, 32'd16);
      slave_wait = 0;
      setup(0, 1'b1, 4'd2, 8'h5A);
      push(0, 1'b1, 4'd2, 8'h5A, 1'b0, 8'h00);
      req[0] = 1'b1;
      wait_ack(0, 1'b1);

      // pready on the timeout cycle wins; req dropped mid-REQ still completes.
      slave_wait = 15;
      slave_data = 8'h5D;
      setup(1, 1'b0, 4'd9, 8'h00);
      push(1, 1'b0, 4'd9, 8'h00, 1'b0, 8'h5D);
      req[1] = 1'b1;
      wait_newd();
      repeat (2) @(negedge clk);
      req[1] = 1'b0;
      wait_ack(1, 1'b0);
      repeat (4) @(negedge clk);
      chk("dropped_idle", {31'd0, busy}, 32'd0);

      // Reset mid-REQ aborts silently; then all four requesting, expect 0,1,2,3,0.
      slave_wait = 1000;
      setup(1, 1'b1, 4'd7, 8'h99);
      exp_xfer.push_back('{1, 1'b1, 4'd7, 8'h99});
      req[1] = 1'b1;
      wait_newd();
      repeat (3) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_newd", {31'd0, m_newd}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_gnt", {29'd0, gnt_id}, 32'd0);
      chk("rst_mid_ack", {28'd0, ack}, 32'd0);
      slave_wait = 0;
      slave_data = 8'h3E;
      setup(0, 1'b1, 4'd2, 8'h11);
      setup(1, 1'b1, 4'd4, 8'h22);
      setup(2, 1'b0, 4'd6, 8'h33);
      setup(3, 1'b1, 4'd8, 8'h44);
      push(0, 1'b1, 4'd2, 8'h11, 1'b0, 8'h00);
      push(1, 1'b1, 4'd4, 8'h22, 1'b0, 8'h00);
      push(2, 1'b0, 4'd6, 8'h33, 1'b0, 8'h3E);
      push(3, 1'b1, 4'd8, 8'h44, 1'b0, 8'h00);
      push(0, 1'b1, 4'd2, 8'h11, 1'b0, 8'h00);
      req = 4'b1111;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      wait_ack(0, 1'b0);
      wait_ack(1, 1'b1);
      wait_ack(2, 1'b1);
      wait_ack(3, 1'b1);
      wait_ack(0, 1'b1);

      repeat (6) @(negedge clk);
      chk("ack_q_empty", exp_ack.size(), 32'd0);
      chk("xfer_q_empty", exp_xfer.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
